// File: rtl/aes_gf_pkg.sv
// ---------------------------------------------------------------------------
// aes_gf_pkg
//   Shared GF(2^8) helpers and constants for the AES column-mixing datapath.
//   Contents:
//     STATE_W / COL_W  : state and column widths (128 / 32)
//     POLY             : reduction byte for x^8+x^4+x^3+x+1
//     mix_state_e      : FSM states of the iterative engine
//     xtime            : multiply by x in GF(2^8)
//     get_byte         : row r of a 32-bit column (row 0 = MSB)
//     get_col/set_col  : column c of a 128-bit state (column 0 = MSBs)
// ---------------------------------------------------------------------------
package aes_gf_pkg;

  localparam int unsigned STATE_W = 128;
  localparam int unsigned COL_W   = 32;
  localparam logic [7:0]  POLY    = 8'h1B;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mix_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] x,
                                       input logic [7:0] poly = POLY);
    return {x[6:0], 1'b0} ^ (x[7] ? poly : 8'h00);
  endfunction

  function automatic logic [7:0] get_byte(input logic [COL_W-1:0] col,
                                          input logic [1:0]       row);
    int unsigned top;
    top = COL_W - 1 - 8 * 32'(row);
    return col[top -: 8];
  endfunction

  function automatic logic [COL_W-1:0] get_col(input logic [STATE_W-1:0] s,
                                               input logic [1:0]         idx);
    int unsigned top;
    top = STATE_W - 1 - COL_W * 32'(idx);
    return s[top -: COL_W];
  endfunction

  function automatic logic [STATE_W-1:0] set_col(input logic [STATE_W-1:0] s,
                                                 input logic [1:0]         idx,
                                                 input logic [COL_W-1:0]   col);
    logic [STATE_W-1:0] r;
    int unsigned        top;
    r   = s;
    top = STATE_W - 1 - COL_W * 32'(idx);
    r[top -: COL_W] = col;
    return r;
  endfunction

endpackage

// File: rtl/mix_column_word.sv
// ---------------------------------------------------------------------------
// mix_column_word
//   Combinational MixColumns of one 32-bit column (row 0 in bits 31:24).
//   Multiples are formed from xtime chains only (no lookup tables).
//   Optional macro MIX_INV_EN adds mode_inv and the InvMixColumns path.
//   Ports:
//     col_in   [31:0] in   column a0..a3
//     mode_inv        in   1 = InvMixColumns (only with MIX_INV_EN)
//     col_out  [31:0] out  mixed column b0..b3
// ---------------------------------------------------------------------------
module mix_column_word
  import aes_gf_pkg::*;
#(
  parameter logic [7:0] POLY = 8'h1B
) (
  input  logic [COL_W-1:0] col_in,
`ifdef MIX_INV_EN
  input  logic             mode_inv,
`endif
  output logic [COL_W-1:0] col_out
);

  logic [7:0]       a  [4];
  logic [7:0]       x2 [4];
  logic [7:0]       x3 [4];
  logic [COL_W-1:0] fwd_word;
`ifdef MIX_INV_EN
  logic [7:0]       x4 [4];
  logic [7:0]       x8 [4];
  logic [COL_W-1:0] inv_word;
`endif

  always_comb begin
    for (int unsigned r = 0; r < 4; r++) begin
      a[r]  = get_byte(col_in, 2'(r));
      x2[r] = xtime(a[r], POLY);
      x3[r] = x2[r] ^ a[r];
`ifdef MIX_INV_EN
      x4[r] = xtime(x2[r], POLY);
      x8[r] = xtime(x4[r], POLY);
`endif
    end
  end

  // Row r uses the circulant {2,3,1,1} starting at a[r].
  always_comb begin
    fwd_word = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      fwd_word[31 - 8*r -: 8] = x2[r] ^ x3[(r + 1) & 3] ^ a[(r + 2) & 3] ^ a[(r + 3) & 3];
    end
  end

`ifdef MIX_INV_EN
  // Row r uses the circulant {14,11,13,9} starting at a[r]:
  // 14 = 8^4^2, 11 = 8^2^1, 13 = 8^4^1, 9 = 8^1.
  always_comb begin
    inv_word = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      inv_word[31 - 8*r -: 8] =
          (x8[r]           ^ x4[r]           ^ x2[r])
        ^ (x8[(r + 1) & 3] ^ x2[(r + 1) & 3] ^ a[(r + 1) & 3])
        ^ (x8[(r + 2) & 3] ^ x4[(r + 2) & 3] ^ a[(r + 2) & 3])
        ^ (x8[(r + 3) & 3] ^ a[(r + 3) & 3]);
    end
  end

  assign col_out = mode_inv ? inv_word : fwd_word;
`else
  assign col_out = fwd_word;
`endif

endmodule

// File: rtl/mix_columns_seq.sv
// ---------------------------------------------------------------------------
// mix_columns_seq
//   Iterative AES-128 MixColumns engine: one 32-bit column per clock,
//   4 cycles per state, valid/ready handshakes on both sides.
//   Optional macro MIX_INV_EN adds the mode_inv port (InvMixColumns).
//   Ports:
//     clk        in   rising-edge clock
//     rst_n      in   asynchronous active-low reset
//     in_valid   in   input state valid
//     in_ready   out  engine can accept a state (IDLE, or DONE with out_ready)
//     in_state   in   128-bit input state, byte 0 in bits 127:120
//     out_valid  out  mixed state available
//     out_ready  in   downstream accepts the mixed state
//     out_state  out  128-bit mixed state
//     mode_inv   in   1 selects InvMixColumns (only with MIX_INV_EN)
// ---------------------------------------------------------------------------
module mix_columns_seq
  import aes_gf_pkg::*;
#(
  parameter int unsigned NUM_COLS = 4,
  parameter logic [7:0]  POLY     = 8'h1B
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state
`ifdef MIX_INV_EN
  ,
  input  logic               mode_inv
`endif
);

  if (NUM_COLS != 4) begin : g_num_cols_check
    $error("mix_columns_seq: NUM_COLS must be 4 for AES-128");
  end

  mix_state_e         state;
  logic [1:0]         col_cnt;
  logic [STATE_W-1:0] work;
  logic [COL_W-1:0]   col_cur;
  logic [COL_W-1:0]   col_mixed;
  logic               accept;
`ifdef MIX_INV_EN
  logic               mode_r;
`endif

  assign col_cur = get_col(work, col_cnt);

  mix_column_word #(
    .POLY(POLY)
  ) u_mix_column_word (
    .col_in  (col_cur),
`ifdef MIX_INV_EN
    .mode_inv(mode_r),
`endif
    .col_out (col_mixed)
  );

  // Ready depends only on FSM state and out_ready, never on in_state.
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_ready && in_valid;
  assign out_state = work;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      col_cnt   <= '0;
      work      <= '0;
      out_valid <= 1'b0;
`ifdef MIX_INV_EN
      mode_r    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            work    <= in_state;
            col_cnt <= '0;
            state   <= BUSY;
`ifdef MIX_INV_EN
            mode_r  <= mode_inv;
`endif
          end
        end

        BUSY: begin
          work    <= set_col(work, col_cnt, col_mixed);
          col_cnt <= col_cnt + 2'd1;
          if (col_cnt == 2'd3) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            // Output transfer and next acceptance share this edge.
            if (in_valid) begin
              work    <= in_state;
              col_cnt <= '0;
              state   <= BUSY;
`ifdef MIX_INV_EN
              mode_r  <= mode_inv;
`endif
            end else begin
              state <= IDLE;
            end
          end
        end

        default: begin
          state     <= IDLE;
          col_cnt   <= '0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// ---------------------------------------------------------------------------
// tb_mix_columns_seq
//   Scoreboard bench for mix_columns_seq. Expected states come from
//   directed constants or a matrix-multiply reference over GF(2^8).
// ---------------------------------------------------------------------------
module tb_mix_columns_seq;

`ifdef MIX_INV_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V2_IN    = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
  localparam logic [127:0] V2_OUT   = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_state = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_state;
`ifdef MIX_INV_EN
  logic         mode_inv = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rdy_mode = 0;   // 0: always ready, 1: random, 2: follow man_ready
  logic man_ready = 1'b1;
  logic ov_prev   = 1'b0;

  logic [127:0] exp_q[$];
  int           acc_q[$];

  mix_columns_seq #(
    .NUM_COLS(4),
    .POLY    (8'h1B)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_state (in_state),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_state(out_state)
`ifdef MIX_INV_EN
    ,
    .mode_inv (mode_inv)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = man_ready;
    endcase
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s, input bit inv);
    logic [7:0]   coef[4];
    logic [7:0]   a[4];
    logic [7:0]   b;
    logic [127:0] r = '0;
    if (inv) coef = '{8'd14, 8'd11, 8'd13, 8'd9};
    else     coef = '{8'd2, 8'd3, 8'd1, 8'd1};
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = s[127 - 8*(4*c + k) -: 8];
      for (int row = 0; row < 4; row++) begin
        b = 8'h00;
        for (int k = 0; k < 4; k++) b = b ^ gmul(a[k], coef[(k - row + 4) % 4]);
        r[127 - 8*(4*c + row) -: 8] = b;
      end
    end
    return r;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic summary_and_finish();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timeout waiting on DUT at cycle %0d", name, cyc);
    summary_and_finish();
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      ov_prev = 1'b0;
    end else begin
      if (out_valid && !ov_prev) begin
        if (acc_q.size() == 0) begin
          chk("unexpected_out_valid", 128'(out_valid), 128'(0));
        end else begin
          int a;
          a = acc_q.pop_front();
          chk("latency", 128'(cyc - a), 128'(4));
        end
      end
      ov_prev = out_valid;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_output", out_state, 128'hx);
        end else begin
          logic [127:0] e;
          e = exp_q.pop_front();
          chk("out_state", out_state, e);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [127:0] s, input bit m, input logic [127:0] exp,
                      output int waits);
    in_state = s;
`ifdef MIX_INV_EN
    mode_inv = m;
`endif
    in_valid = 1'b1;
    waits    = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
      if (waits > 300) timeout("send_accept");
    end
    exp_q.push_back(exp);
    acc_q.push_back(cyc + 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_state = {$urandom(), $urandom(), $urandom(), $urandom()};
`ifdef MIX_INV_EN
    mode_inv = 1'($urandom_range(0, 1));
`endif
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 300) timeout(name);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int           w;
    int           n;
    logic [127:0] s;
    logic [127:0] f;
    bit           m;

    #2;
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_out_state", out_state, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;

    // Directed vectors
    send(FIPS_IN, 1'b0, FIPS_OUT, w);
    drain("drain_fips");
    send(V2_IN, 1'b0, V2_OUT, w);
    drain("drain_v2");

    // Backpressure, then same-edge hand-over to the next state
    rdy_mode  = 2;
    man_ready = 1'b0;
    @(posedge clk);
    #1;
    send(V2_IN, 1'b0, V2_OUT, w);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n > 20) timeout("bp_out_valid");
    end while (!out_valid);
    repeat (10) begin
      @(negedge clk);
      chk("bp_out_state", out_state, V2_OUT);
      chk("bp_out_valid", 128'(out_valid), 128'(1));
      chk("bp_in_ready", 128'(in_ready), 128'(0));
    end
    man_ready = 1'b1;
    @(posedge clk);
    #1;
    send(FIPS_IN, 1'b0, FIPS_OUT, w);
    chk("same_edge_accept_waits", 128'(w), 128'(0));
    rdy_mode = 0;
    drain("drain_bp");

    // Reset in the middle of BUSY after two columns
    send(V2_IN, 1'b0, V2_OUT, w);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_out_state", out_state, '0);
    void'(exp_q.pop_back());
    void'(acc_q.pop_back());
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    repeat (8) begin
      @(negedge clk);
      chk("midrst_no_stale", 128'(out_valid), 128'(0));
    end
    @(posedge clk);
    #1;
    send(FIPS_IN, 1'b0, FIPS_OUT, w);
    drain("drain_after_reset");

    if (INV) begin
      send(FIPS_OUT, 1'b1, FIPS_IN, w);
      drain("drain_inv");
      for (int i = 0; i < 8; i++) begin
        s = {$urandom(), $urandom(), $urandom(), $urandom()};
        f = ref_mix(s, 1'b0);
        send(s, 1'b0, f, w);
        send(f, 1'b1, s, w);
      end
      drain("drain_roundtrip");
    end

    // Random stream with gaps on both handshakes
    rdy_mode = 1;
    for (int i = 0; i < 100; i++) begin
      s = {$urandom(), $urandom(), $urandom(), $urandom()};
      m = INV ? 1'($urandom_range(0, 1)) : 1'b0;
      send(s, m, ref_mix(s, m), w);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    drain("drain_stream");
    rdy_mode = 0;
    repeat (3) @(negedge clk);
    chk("final_queue_empty", 128'(exp_q.size()), 128'(0));

    summary_and_finish();
  end

  initial begin
    #500000;
    timeout("global");
  end

endmodule

// File: doc/mix_columns_seq.md
Name: mix_columns_seq

Overview:
- Iterative AES-128 MixColumns engine for the encryption datapath; the forward counterpart of the decryption-side InvMixColumns constant multipliers (×9/×11/×13/×14).
- Accepts a 128-bit state over a valid/ready handshake and processes one 32-bit column per clock.
- Returns the mixed state over a second valid/ready handshake.
- Sits between ShiftRows and AddRoundKey in the round pipeline.

Parameters:
- NUM_COLS, 4, columns per state; fixed for AES-128, and any other value is a synthesis error.
- POLY, 8'h1B, reduction byte for x^8+x^4+x^3+x+1 used by xtime.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input state valid.
- in_ready  out  1  engine can accept an input state.
- in_state  in  128  input state.
- out_valid  out  1  mixed state available.
- out_ready  in  1  downstream accepts the mixed state.
- out_state  out  128  mixed state.
- mode_inv  in  1  present only with MIX_INV_EN; 1 selects InvMixColumns.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Byte order follows FIPS-197:
  - Byte k = in_state[127-8k -: 8].
  - Column c = bytes 4c..4c+3, with row 0 as the most significant byte.
- Forward mix per column (a0..a3 → b0..b3):
  - b0 = 2a0^3a1^a2^a3
  - b1 = a0^2a1^3a2^a3
  - b2 = a0^a1^2a2^3a3
  - b3 = 3a0^a1^a2^2a3
  - 2x = xtime(x) = {x[6:0],1'b0} ^ (x[7] ? POLY : 0); 3x = 2x^x.
  - Arithmetic uses xtime; no 256-entry lookup tables.
- FSM states: IDLE, BUSY, DONE. Column counter col_cnt is 2 bits.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_state (and mode_inv) into the working register, col_cnt←0, go to BUSY.
- BUSY:
  - in_ready=0, out_valid=0.
  - Each edge replaces column col_cnt of the working register with its mixed value, then col_cnt←col_cnt+1.
  - When col_cnt==3, go to DONE. BUSY lasts exactly 4 cycles.
- DONE:
  - out_valid=1; out_state = working register.
  - out_state is held stable while out_ready=0.
  - On out_ready: complete the transfer.
  - If in_valid is also high, the new state is accepted on the same edge (in_ready = out_ready in DONE) and the FSM goes directly to BUSY; otherwise it goes to IDLE.
- Latency: out_valid rises 4 cycles after the accepting edge. Back-to-back throughput is 1 state per 5 cycles.
- Inputs are ignored outside accepting edges. in_state may change freely after acceptance.
- Reset (asynchronous, any state including mid-BUSY):
  - FSM→IDLE, col_cnt=0, working register=0.
  - out_valid=0, out_state=0, in_ready=1 after reset release.
  - Any partial result is discarded with no output.
- No outputs are driven combinationally from in_state. in_ready is combinational from FSM state and out_ready only.

Optional Feature:
- Macro: MIX_INV_EN.
- Defined:
  - mode_inv port exists and is latched at acceptance.
  - mode_inv=1 applies InvMixColumns:
    - b0 = 14a0^11a1^13a2^9a3, rotating cyclically for b1..b3.
    - Multiples are built from xtime chains: 4x, 8x; 9=8^1, 11=8^2^1, 13=8^4^1, 14=8^4^2.
  - Latency and handshake are unchanged.
- Undefined: port absent; forward mix only; no inverse logic synthesised.

Decomposition:
- Shared package aes_gf_pkg holds:
  - POLY constant.
  - xtime function.
  - STATE_W=128, COL_W=32.
  - FSM state enum.
  - Byte/column extraction helper functions.
- Sub-module mix_column_word (combinational):
  - Ports: 32-bit column in, mode_inv (under MIX_INV_EN), 32-bit column out.
  - Instantiated once; the column is muxed by col_cnt.

Test Plan:
- FIPS-197 vector:
  - in_state = db135345_f20a225c_01010101_c6c6c6c6.
  - Expect out_state = 8e4da1bc_9fdc589d_01010101_c6c6c6c6.
  - out_valid rises exactly 4 cycles after acceptance.
- Second vector:
  - in_state = d4d4d4d5_2d26314c_00000000_ffffffff.
  - Expect out_state = d5d5d7d6_4d7ebdf8_00000000_ffffffff.
- Backpressure:
  - Hold out_ready=0 for 10 cycles in DONE.
  - Expect out_state stable, out_valid=1, in_ready=0.
  - Assert out_ready together with in_valid (next state) and expect same-edge acceptance with no idle cycle.
- Reset mid-BUSY:
  - Drop rst_n after 2 columns.
  - Expect out_valid=0, out_state=0 immediately; after release expect in_ready=1 and no stale output.
  - A fresh run yields correct results.
- MIX_INV_EN:
  - With mode_inv=1, feed 8e4da1bc_9fdc589d_01010101_c6c6c6c6.
  - Expect db135345_f20a225c_01010101_c6c6c6c6.
  - Random forward-then-inverse round trips return the original state.
- Stream: 100 random states with random in_valid/out_ready gaps; results match the reference model in order, with no loss or duplication.
